// File: rtl/spi_master_slave_if.sv
// spi_if: SPI wire bundle shared by master and slave on the system clock
interface spi_if (
    input logic clk
);
    logic sclk;
    logic mosi;
    logic cs_n;
    logic miso;
    modport master (input clk, input miso, output sclk, output mosi, output cs_n);
    modport slave (input clk, input sclk, input mosi, input cs_n, output miso);
endinterface

// File: rtl/spi_master_slave.sv
// spi_master_slave: single-clock 8-bit SPI mode 0 master/slave pair
// SPI_LSB_FIRST_EN selects LSB-first shifting on both sides
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       done,
    output logic [7:0] data_out,
    spi_if.master      spi
);
    localparam int DW = $clog2(CLK_DIV);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    state_t        state;
    logic [7:0]    tx;
    logic [7:0]    rx;
    logic [2:0]    cnt;
    logic [DW-1:0] div;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            spi.sclk <= 1'b0;
            spi.cs_n <= 1'b1;
            spi.mosi <= 1'b0;
            done     <= 1'b0;
            data_out <= 8'h00;
            tx       <= 8'h00;
            rx       <= 8'h00;
            cnt      <= 3'd0;
            div      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= XFER;
                    tx       <= data_in;
                    cnt      <= 3'd0;
                    div      <= '0;
                    spi.cs_n <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
                    spi.mosi <= data_in[0];
`else
                    spi.mosi <= data_in[7];
`endif
                end
                XFER: if (div == DW'(CLK_DIV - 1)) begin
                    div      <= '0;
                    spi.sclk <= ~spi.sclk;
                    if (!spi.sclk) begin
`ifdef SPI_LSB_FIRST_EN
                        rx <= {spi.miso, rx[7:1]};
`else
                        rx <= {rx[6:0], spi.miso};
`endif
                    end else begin
`ifdef SPI_LSB_FIRST_EN
                        tx       <= {1'b0, tx[7:1]};
                        spi.mosi <= tx[1];
`else
                        tx       <= {tx[6:0], 1'b0};
                        spi.mosi <= tx[6];
`endif
                        cnt <= cnt + 3'd1;
                        // eighth falling toggle ends the byte; sclk is already returning to 0
                        if (cnt == 3'd7) begin
                            state    <= DONE;
                            spi.cs_n <= 1'b1;
                            done     <= 1'b1;
                            data_out <= rx;
                        end
                    end
                end else begin
                    div <= div + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module spi_slave (
    input  logic       clk,
    input  logic       rst,
    spi_if.slave       spi,
    input  logic [7:0] slave_data,
    output logic [7:0] received_data
);
    logic [7:0] tx;
    logic [7:0] rx;
    logic       sclk_q;
    logic       cs_q;
`ifdef SPI_LSB_FIRST_EN
    assign spi.miso = tx[0];
`else
    assign spi.miso = tx[7];
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            tx            <= 8'h00;
            rx            <= 8'h00;
            received_data <= 8'h00;
            sclk_q        <= 1'b0;
            cs_q          <= 1'b1;
        end else begin
            sclk_q <= spi.sclk;
            cs_q   <= spi.cs_n;
            // edges are seen one cycle late; safe because sclk holds for at least 2 cycles
            if (spi.cs_n) begin
                tx <= slave_data;
            end else if (spi.sclk && !sclk_q) begin
`ifdef SPI_LSB_FIRST_EN
                rx <= {spi.mosi, rx[7:1]};
`else
                rx <= {rx[6:0], spi.mosi};
`endif
            end else if (!spi.sclk && sclk_q) begin
`ifdef SPI_LSB_FIRST_EN
                tx <= {1'b0, tx[7:1]};
`else
                tx <= {tx[6:0], 1'b0};
`endif
            end
            if (spi.cs_n && !cs_q) received_data <= rx;
        end
    end
endmodule

module spi_master_slave #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic [7:0] slave_data,
    output logic       done,
    output logic [7:0] data_out,
    output logic [7:0] received_data,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    output logic       miso
);
    spi_if spi (clk);
    spi_master #(.CLK_DIV(CLK_DIV)) u_master (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .done(done), .data_out(data_out), .spi(spi)
    );
    spi_slave u_slave (
        .clk(clk), .rst(rst), .spi(spi),
        .slave_data(slave_data), .received_data(received_data)
    );
    assign sclk = spi.sclk;
    assign cs_n = spi.cs_n;
    assign mosi = spi.mosi;
    assign miso = spi.miso;
endmodule

// File: tb/tb_spi_master_slave.sv
// tb_spi_master_slave: scoreboard bench for the SPI master/slave pair
module tb_spi_master_slave;
    localparam int CLK_DIV = 4;
`ifdef SPI_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif
    typedef struct packed {
        logic [7:0] dout;
        logic [7:0] rcv;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] slave_data = 8'h00;
    logic       done;
    logic [7:0] data_out;
    logic [7:0] received_data;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    exp_t       sb[$];
    logic [7:0] last_dout = 8'h00;
    int         passed = 0;
    int         total = 0;

    spi_master_slave #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .slave_data(slave_data), .done(done), .data_out(data_out),
        .received_data(received_data), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic xfer(input logic [7:0] din, input logic [7:0] sdat, input bit glitch);
        int   rises = 0;
        int   low = 0;
        int   dcyc = 0;
        logic prev = 1'b0;
        exp_t e;
        @(negedge clk);
        data_in    = din;
        slave_data = sdat;
        start      = 1'b1;
        sb.push_back('{dout: sdat, rcv: din});
        for (int c = 1; c <= 200 && dcyc == 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                start = 1'b0;
                check("first_mosi", mosi, LSB ? din[0] : din[7]);
                check("first_miso", miso, LSB ? sdat[0] : sdat[7]);
            end
            if (glitch && c == 20) begin
                start   = 1'b1;
                data_in = 8'h11;
            end
            if (glitch && c == 21) start = 1'b0;
            if (c == 30) check("dout_hold", data_out, last_dout);
            if (sclk && !prev) rises++;
            prev = sclk;
            if (!cs_n) low++;
            if (done) dcyc = c;
        end
        check("done_cycle", dcyc, 16 * CLK_DIV + 1);
        check("sclk_rises", rises, 8);
        check("cs_low_cycles", low, 16 * CLK_DIV);
        check("cs_high_at_done", cs_n, 1'b1);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("data_out", data_out, e.dout);
            last_dout = e.dout;
            @(posedge clk);
            #1;
            check("done_single", done, 1'b0);
            repeat (2) @(posedge clk);
            #1;
            check("received_data", received_data, e.rcv);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_miso", miso, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_received", received_data, 8'h00);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        xfer(8'hA5, 8'h3C, 1'b0);
        xfer(8'hFF, 8'h00, 1'b0);
        xfer(8'h00, 8'hFF, 1'b0);
        xfer(8'h96, 8'h4B, 1'b1);
        // abort after three bits: reset wins and the partial byte is dropped
        @(negedge clk);
        data_in    = 8'h5A;
        slave_data = 8'hC3;
        start      = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cs_n", cs_n, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_data_out", data_out, 8'h00);
        check("abort_received", received_data, 8'h00);
        rst       = 1'b0;
        last_dout = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_update", received_data, 8'h00);
        xfer(8'hC7, 8'h81, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
